ddr5_cmd_issuer: RTL and testbench
==================================

DDR5_CMD_ISSUER -- requirements
Module: ddr5_cmd_issuer

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
  TRCD 4: cycles from ACT to RD/WR
  TCL 4: cycles from RD to data start
  TCWD 2: cycles from WR to data start
  TBURST 2: data burst cycles
  TRP 4: cycles from PRE to next accept
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
  clk  in  1  sole clock; all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  req_valid  in  1  request present
  req_ready  out  1  block can accept
  req_op  in  2  0=read, 1=write, 2=ifetch, 3=illegal
  req_core  in  4  requesting core id
  req_addr  in  34  physical byte address
  cmd_valid  out  1  DRAM command issued this cycle
  cmd_code  out  2  0=ACT, 1=RD, 2=WR, 3=PRE
  cmd_bg  out  3  bank group
  cmd_ba  out  2  bank
  cmd_row  out  16  row
  cmd_col  out  10  column
  rsp_valid  out  1  one-cycle completion pulse
  rsp_core  out  4  core of completed request
  rsp_write  out  1  completed request was a write
  err_illegal  out  1  one-cycle pulse on illegal op
REQ-003 SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 Address decode: row=addr[33:18], col={addr[17:12],addr[5:2]}, ba=addr[11:10], bg=addr[9:7]; addr[6] (channel) and addr[1:0] (byte) ignored.
REQ-005 req_ready SHALL be 1 only in IDLE; transfer occurs on an edge with req_valid&&req_ready; op, core and decoded fields are latched then.
REQ-006 FSM states: IDLE, ACT, WAIT_RCD, RDWR, WAIT_DATA, PRE, WAIT_RP; closed-page policy, one request in flight.
REQ-007 Accept at cycle N -> ACT (cmd_valid=1, code 0, bg/ba/row) at N+1.
REQ-008 RD (op 0 or 2) or WR (op 1), with bg/ba/col, SHALL issue exactly TRCD cycles after ACT.
REQ-009 rsp_valid SHALL pulse exactly TCL+TBURST (read) or TCWD+TBURST (write) cycles after RD/WR, with rsp_core and rsp_write valid that cycle.
REQ-010 PRE (bg/ba) SHALL issue the cycle after rsp_valid; req_ready SHALL rise exactly TRP cycles after PRE.
REQ-011 cmd_valid SHALL be 1 only on ACT/RD/WR/PRE cycles; cmd fields and rsp_core/rsp_write are 0 when their valid is 0.
REQ-012 op 3 accepted -> err_illegal pulses next cycle, no command, FSM remains IDLE.
REQ-013 Wait counters SHALL be wide enough for max(TRCD,TCL,TCWD,TRP)+TBURST, count down to 1, no wrap; parameter value 1 gives back-to-back commands.
REQ-014 req_valid or req_* changes outside IDLE SHALL be ignored.

Reset
REQ-015 On rst_n low, immediately: FSM=IDLE, counters 0, all outputs 0 except req_ready, which SHALL become 1 on the first edge after rst_n deasserts.
REQ-016 Reset mid-sequence SHALL abort the request with no further command or rsp_valid.

Structure
REQ-017 Shared package SHALL hold the cmd_code and req_op enums, the address-map bit positions and the decoded-address struct.
REQ-018 One sub-module is natural: ddr5_addr_decode (combinational decode per REQ-004).

Verification
REQ-019 Read 0x3_FFFC_0A8C, core 5, accept cycle 0 -> ACT@1 (row 0xFFFF, bg 5, ba 2), RD@5 (col 0x003), rsp@11 core 5 write 0, PRE@12, req_ready@16.
REQ-020 Write addr 0, accept cycle 0 -> ACT@1, WR@5, rsp@9 with rsp_write=1, PRE@10, req_ready@14.
REQ-021 op 3 accept -> err_illegal@1, no cmd_valid, req_ready stays 1.
REQ-022 rst_n low at cycle 7 of REQ-019 sequence -> outputs 0 at once, no rsp or PRE; new request completes normally after release.
REQ-023 req_valid held high for 3 back-to-back reads -> accepts spaced exactly 16 cycles, no overlap of commands.
REQ-024 TRCD=1, TRP=1 -> RD on cycle after ACT, req_ready on cycle after PRE.

Source files
------------

// File: rtl/ddr5_cmd_issuer_pkg.sv
// Shared definitions for the DDR5 command issuer:
//   - cmd_code_e : DRAM command encodings driven on cmd_code
//   - req_op_e   : request opcodes accepted on req_op
//   - address-map bit positions and the decoded-address struct
//   - max4       : helper used to size the wait counter
package ddr5_cmd_issuer_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_code_e;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } req_op_e;

  localparam int ADDR_W  = 34;
  // Address map: row | col_hi | ba | bg | channel | col_lo | byte
  localparam int ROW_HI  = 33;
  localparam int ROW_LO  = 18;
  localparam int COLH_HI = 17;
  localparam int COLH_LO = 12;
  localparam int BA_HI   = 11;
  localparam int BA_LO   = 10;
  localparam int BG_HI   = 9;
  localparam int BG_LO   = 7;
  localparam int CH_BIT  = 6;
  localparam int COLL_HI = 5;
  localparam int COLL_LO = 2;

  typedef struct packed {
    logic [2:0]  bg;
    logic [1:0]  ba;
    logic [15:0] row;
    logic [9:0]  col;
  } dec_addr_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ddr5_addr_decode.sv
// Combinational physical-address decode into DRAM coordinates.
//   addr : 34-bit physical byte address
//   dec  : bank group / bank / row / column
// The channel bit and byte offset are not part of the DRAM coordinate.
module ddr5_addr_decode
  import ddr5_cmd_issuer_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output dec_addr_t         dec
);

  logic unused_bits;
  assign unused_bits = ^{addr[CH_BIT], addr[1:0]};

  assign dec.row = addr[ROW_HI:ROW_LO];
  assign dec.col = {addr[COLH_HI:COLH_LO], addr[COLL_HI:COLL_LO]};
  assign dec.ba  = addr[BA_HI:BA_LO];
  assign dec.bg  = addr[BG_HI:BG_LO];

endmodule

// File: rtl/ddr5_cmd_issuer.sv
// Single-request, closed-page DDR5 command issuer.
// Accepts one request in IDLE, then sequences ACT -> RD/WR -> (data) ->
// completion pulse -> PRE -> precharge wait -> IDLE.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/ready/op/core/addr  request handshake and payload
//   cmd_valid/code/bg/ba/row/col  DRAM command bus (fields zero when idle)
//   rsp_valid/core/write       one-cycle completion pulse
//   err_illegal                one-cycle pulse after an illegal op is accepted
module ddr5_cmd_issuer
  import ddr5_cmd_issuer_pkg::*;
#(
  parameter int TRCD   = 4,
  parameter int TCL    = 4,
  parameter int TCWD   = 2,
  parameter int TBURST = 2,
  parameter int TRP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [3:0]  req_core,
  input  logic [33:0] req_addr,
  output logic        cmd_valid,
  output logic [1:0]  cmd_code,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        rsp_valid,
  output logic [3:0]  rsp_core,
  output logic        rsp_write,
  output logic        err_illegal
);

  localparam int CW = $clog2(max4(TRCD, TCL, TCWD, TRP) + TBURST + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_RDWR, S_WAIT_DATA, S_PRE, S_WAIT_RP
  } state_e;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rdy_q, err_q, wr_q;
  logic [3:0]    core_q;
  dec_addr_t     dec_in, dec_q;
  logic          accept, legal;

  ddr5_addr_decode u_dec (.addr(req_addr), .dec(dec_in));

  assign accept = req_valid && req_ready;
  assign legal  = (req_op != OP_ILLEGAL);

  // rdy_q holds req_ready low until the first edge after reset release.
  assign req_ready   = rdy_q && (state == S_IDLE);
  assign err_illegal = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      core_q <= '0;
      dec_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      err_q <= accept && !legal;
      if (accept && legal) begin
        dec_q  <= dec_in;
        core_q <= req_core;
        wr_q   <= (req_op == OP_WRITE);
      end
    end
  end

  // Each wait state is entered with (remaining cycles) and leaves at 1,
  // so a timing parameter of 1 skips its wait state entirely.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: if (accept && legal) state_nxt = S_ACT;
      S_ACT: begin
        if (TRCD <= 1) state_nxt = S_RDWR;
        else begin
          state_nxt = S_WAIT_RCD;
          cnt_nxt   = CW'(TRCD - 1);
        end
      end
      S_WAIT_RCD: begin
        if (cnt <= CW'(1)) begin
          state_nxt = S_RDWR;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt - 1'b1;
      end
      S_RDWR: begin
        state_nxt = S_WAIT_DATA;
        cnt_nxt   = wr_q ? CW'(TCWD + TBURST) : CW'(TCL + TBURST);
      end
      // Completion pulses on the last data-wait cycle.
      S_WAIT_DATA: begin
        if (cnt <= CW'(1)) begin
          state_nxt = S_PRE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt - 1'b1;
      end
      S_PRE: begin
        if (TRP <= 1) state_nxt = S_IDLE;
        else begin
          state_nxt = S_WAIT_RP;
          cnt_nxt   = CW'(TRP - 1);
        end
      end
      S_WAIT_RP: begin
        if (cnt <= CW'(1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt - 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_code  = CMD_ACT;
    cmd_bg    = '0;
    cmd_ba    = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    rsp_valid = 1'b0;
    rsp_core  = '0;
    rsp_write = 1'b0;
    case (state)
      S_ACT: begin
        cmd_valid = 1'b1;
        cmd_code  = CMD_ACT;
        cmd_bg    = dec_q.bg;
        cmd_ba    = dec_q.ba;
        cmd_row   = dec_q.row;
      end
      S_RDWR: begin
        cmd_valid = 1'b1;
        cmd_code  = wr_q ? CMD_WR : CMD_RD;
        cmd_bg    = dec_q.bg;
        cmd_ba    = dec_q.ba;
        cmd_col   = dec_q.col;
      end
      S_WAIT_DATA: begin
        if (cnt == CW'(1)) begin
          rsp_valid = 1'b1;
          rsp_core  = core_q;
          rsp_write = wr_q;
        end
      end
      S_PRE: begin
        cmd_valid = 1'b1;
        cmd_code  = CMD_PRE;
        cmd_bg    = dec_q.bg;
        cmd_ba    = dec_q.ba;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
// Self-checking bench for ddr5_cmd_issuer. Two instances: dut_a with
// default timing, dut_b with TRCD=1/TRP=1. Each cycle's full output
// vector is compared with a schedule computed from the request's accept
// cycle and the timing parameters.
module tb_ddr5_cmd_issuer;

  localparam int TCL = 4, TCWD = 2, TBURST = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid_b;
  logic [1:0]  req_op;
  logic [3:0]  req_core;
  logic [33:0] req_addr;

  logic        rdy_a, cv_a, rv_a, rw_a, err_a;
  logic [1:0]  code_a, ba_a;
  logic [2:0]  bg_a;
  logic [15:0] row_a;
  logic [9:0]  col_a;
  logic [3:0]  rc_a;
  logic        rdy_b, cv_b, rv_b, rw_b, err_b;
  logic [1:0]  code_b, ba_b;
  logic [2:0]  bg_b;
  logic [15:0] row_b;
  logic [9:0]  col_b;
  logic [3:0]  rc_b;

  logic [41:0] obs_a, obs_b;
  assign obs_a = {rdy_a, cv_a, code_a, bg_a, ba_a, row_a, col_a, rv_a, rc_a, rw_a, err_a};
  assign obs_b = {rdy_b, cv_b, code_b, bg_b, ba_b, row_b, col_b, rv_b, rc_b, rw_b, err_b};

  localparam logic [41:0] V_ZERO  = '0;
  localparam logic [41:0] V_READY = {1'b1, 41'b0};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr5_cmd_issuer dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
    .req_op(req_op), .req_core(req_core), .req_addr(req_addr),
    .cmd_valid(cv_a), .cmd_code(code_a), .cmd_bg(bg_a), .cmd_ba(ba_a),
    .cmd_row(row_a), .cmd_col(col_a), .rsp_valid(rv_a), .rsp_core(rc_a),
    .rsp_write(rw_a), .err_illegal(err_a)
  );

  ddr5_cmd_issuer #(.TRCD(1), .TRP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(rdy_b),
    .req_op(req_op), .req_core(req_core), .req_addr(req_addr),
    .cmd_valid(cv_b), .cmd_code(code_b), .cmd_bg(bg_b), .cmd_ba(ba_b),
    .cmd_row(row_b), .cmd_col(col_b), .rsp_valid(rv_b), .rsp_core(rc_b),
    .rsp_write(rw_b), .err_illegal(err_b)
  );

  // Expected outputs r cycles after the accept cycle.
  function automatic logic [41:0] exp_vec(input logic [1:0] op, input logic [3:0] core,
                                          input logic [33:0] addr, input int trcd,
                                          input int trp, input int r);
    int lat, t_cmd, t_rsp, t_pre, t_rdy;
    logic rdy, cv, rv, rw, err;
    logic [1:0] code, ba;
    logic [2:0] bg;
    logic [15:0] row;
    logic [9:0] col;
    logic [3:0] rc;
    lat   = (op == 2'd1) ? TCWD + TBURST : TCL + TBURST;
    t_cmd = 1 + trcd;
    t_rsp = t_cmd + lat;
    t_pre = t_rsp + 1;
    t_rdy = t_pre + trp;
    rdy = 0; cv = 0; rv = 0; rw = 0; err = 0;
    code = 0; ba = 0; bg = 0; row = 0; col = 0; rc = 0;
    if (op == 2'd3) begin
      rdy = 1'b1;
      err = (r == 1);
    end else begin
      rdy = (r >= t_rdy);
      if (r == 1) begin
        cv = 1; code = 2'd0;
        bg = 3'((addr >> 7) & 7); ba = 2'((addr >> 10) & 3); row = 16'(addr >> 18);
      end
      if (r == t_cmd) begin
        cv = 1; code = (op == 2'd1) ? 2'd2 : 2'd1;
        bg = 3'((addr >> 7) & 7); ba = 2'((addr >> 10) & 3);
        col = 10'((((addr >> 12) & 63) * 16) + ((addr >> 2) & 15));
      end
      if (r == t_rsp) begin
        rv = 1; rc = core; rw = (op == 2'd1);
      end
      if (r == t_pre) begin
        cv = 1; code = 2'd3;
        bg = 3'((addr >> 7) & 7); ba = 2'((addr >> 10) & 3);
      end
    end
    return {rdy, cv, code, bg, ba, row, col, rv, rc, rw, err};
  endfunction

  // Entered at #1 after a posedge with the selected DUT idle and ready.
  // While busy, random junk is driven on the request bus with valid high.
  task automatic run_txn(input string name, input bit use_b, input logic [1:0] op,
                         input logic [3:0] core, input logic [33:0] addr,
                         input bit chain, input int abort_at);
    int trcd, trp, r_end;
    logic [41:0] obs, exp;
    trcd  = use_b ? 1 : 4;
    trp   = use_b ? 1 : 4;
    r_end = (op == 2'd3) ? 2 : 2 + trcd + ((op == 2'd1) ? TCWD : TCL) + TBURST + trp;
    req_op = op; req_core = core; req_addr = addr;
    if (use_b) req_valid_b = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    for (int r = 1; r <= r_end; r++) begin
      obs = use_b ? obs_b : obs_a;
      exp = exp_vec(op, core, addr, trcd, trp, r);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s r=%0d got=%h exp=%h", name, r, obs, exp);
      end
      if (r == abort_at) begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid_b = 1'b0;
        #1;
        checks++;
        if (obs_a !== V_ZERO) begin
          errors++;
          $display("FAIL %s_rst_now got=%h exp=%h", name, obs_a, V_ZERO);
        end
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          checks++;
          if (obs_a !== V_ZERO) begin
            errors++;
            $display("FAIL %s_rst_hold got=%h exp=%h", name, obs_a, V_ZERO);
          end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
          @(posedge clk); #1;
          checks++;
          if (obs_a !== V_READY) begin
            errors++;
            $display("FAIL %s_post_rst k=%0d got=%h exp=%h", name, k, obs_a, V_READY);
          end
        end
        return;
      end
      if (r < r_end) begin
        if (op == 2'd3) begin
          req_valid = 1'b0; req_valid_b = 1'b0;
        end else begin
          req_op   = 2'($urandom);
          req_core = 4'($urandom);
          req_addr = {2'($urandom), 32'($urandom)};
        end
        @(posedge clk); #1;
      end
    end
    if (!chain) begin
      req_valid = 1'b0; req_valid_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0;
    req_op = '0; req_core = '0; req_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== V_ZERO) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, V_ZERO); end
    checks++;
    if (obs_b !== V_ZERO) begin errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, V_ZERO); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_a !== V_ZERO) begin errors++; $display("FAIL release_a got=%h exp=%h", obs_a, V_ZERO); end
    @(posedge clk); #1;
    checks++;
    if (obs_a !== V_READY) begin errors++; $display("FAIL ready_a got=%h exp=%h", obs_a, V_READY); end
    checks++;
    if (obs_b !== V_READY) begin errors++; $display("FAIL ready_b got=%h exp=%h", obs_b, V_READY); end
  endtask

  task automatic test_read();
    run_txn("read_dir", 1'b0, 2'd0, 4'd5, 34'h3_FFFC_0A8C, 1'b0, 0);
    // Hand-derived fields for this address: row FFFF, bg 5, ba 2, col 3.
    checks++;
    if (exp_vec(2'd0, 4'd5, 34'h3_FFFC_0A8C, 4, 4, 1) !==
        {1'b0, 1'b1, 2'd0, 3'd5, 2'd2, 16'hFFFF, 10'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_decode_model got=%h", exp_vec(2'd0, 4'd5, 34'h3_FFFC_0A8C, 4, 4, 1));
    end
  endtask

  task automatic test_write();
    run_txn("write_dir", 1'b0, 2'd1, 4'd9, 34'h0, 1'b0, 0);
  endtask

  task automatic test_illegal();
    run_txn("illegal", 1'b0, 2'd3, 4'd3, 34'h1_2345_6789, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    run_txn("rst_mid", 1'b0, 2'd0, 4'd5, 34'h3_FFFC_0A8C, 1'b0, 7);
    run_txn("after_rst", 1'b0, 2'd2, 4'd7, 34'h2_A5A5_5A5C, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b0", 1'b0, 2'd0, 4'd1, 34'h1_0000_0F00, 1'b1, 0);
    run_txn("b2b1", 1'b0, 2'd0, 4'd2, 34'h0_8000_0480, 1'b1, 0);
    run_txn("b2b2", 1'b0, 2'd0, 4'd3, 34'h2_0001_2344, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_txn("rand", 1'b0, 2'($urandom_range(0, 3)), 4'($urandom),
              {2'($urandom), 32'($urandom)}, 1'($urandom), 0);
  endtask

  task automatic test_short_timing();
    run_txn("short_rd", 1'b1, 2'd0, 4'd4, 34'h1_1111_1110, 1'b0, 0);
    run_txn("short_wr", 1'b1, 2'd1, 4'd6, 34'h0_F0F0_F0F0, 1'b0, 0);
    run_txn("short_if", 1'b1, 2'd2, 4'd8, {2'($urandom), 32'($urandom)}, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    req_valid = 1'b0;
    @(posedge clk); #1;
    test_short_timing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
